// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- hazard, flush and memory-stall controller for a 4-register
// in-order pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   id_rs1, id_rs2       source registers of the ID instruction
//   id_use_rs1/_rs2      ID instruction really reads rs1 / rs2
//   ex_rd, ex_memread    destination register / load flag of the EX instruction
//   mem_branch_taken     branch in MEM resolved taken
//   mem_busy             data memory not ready this cycle
//   *_en, *_clr          combinational load enables / synchronous clears
//   valid[3:0]           per-register valid bits (IF/ID .. MEM/WB)
//   stall_cnt, flush_cnt saturating event counters
//   timeout_err          sticky mem_busy timeout flag
//   state                RUN=0, MEMWAIT=1, HALT=2
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             mem_branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             exmem_clr,
  output logic             memwb_clr,
  output logic [3:0]       valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err,
  output logic [1:0]       state
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } state_t;

  state_t              st, st_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
  logic                tmo_set;
  logic                lu, fl, frozen;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Register 31 is the zero register, so a load targeting it never hazards.
  assign lu = valid[1] & valid[0] & ex_memread & (ex_rd != 5'd31) &
              ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign fl = mem_branch_taken & valid[2];

  // Any busy cycle or HALT freezes the whole pipeline, valid bits included.
  assign frozen = (st == HALT) | mem_busy;
  assign state  = st;

  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    exmem_en  = 1'b1;
    memwb_en  = 1'b1;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    memwb_clr = 1'b0;
    st_nxt    = st;
    wait_nxt  = wait_cnt;
    tmo_set   = 1'b0;
    if (reset) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      {ifid_clr, idex_clr, exmem_clr, memwb_clr}    = 4'b1111;
    end else if (st == HALT) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
    end else if (mem_busy) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      if (st == RUN) begin
        st_nxt   = MEMWAIT;
        wait_nxt = WAIT_W'(1);
      end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
        // MAX_WAIT busy cycles already tolerated; this one times out.
        st_nxt  = HALT;
        tmo_set = 1'b1;
      end else begin
        wait_nxt = wait_cnt + WAIT_W'(1);
      end
    end else begin
      // MEMWAIT with memory ready behaves exactly like RUN for this cycle.
      st_nxt   = RUN;
      wait_nxt = '0;
      if (fl) begin
        ifid_clr  = 1'b1;
        idex_clr  = 1'b1;
        exmem_clr = 1'b1;
      end else if (lu) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_clr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= RUN;
      wait_cnt    <= '0;
      valid       <= 4'b0000;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      st       <= st_nxt;
      wait_cnt <= wait_nxt;
      if (tmo_set)
        timeout_err <= 1'b1;
      if (!frozen) begin
        // A stall keeps the ID instruction in place; the bubble goes into ID/EX.
        valid[0] <= (lu & ~fl) ? valid[0] : ~fl;
        valid[1] <= valid[0] & ~fl & ~lu;
        valid[2] <= valid[1] & ~fl;
        valid[3] <= valid[2];
      end
      if (st != HALT && (mem_busy || (lu && !fl)))
        stall_cnt <= sat_inc(stall_cnt);
      if (st != HALT && !mem_busy && fl)
        flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- directed self-checking bench for pipe_ctrl. A second
// instance with 4-bit counters shares all inputs and is used for saturation.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_memread, mem_branch_taken, mem_busy;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_clr, idex_clr, exmem_clr, memwb_clr;
  logic [3:0]  valid;
  logic [15:0] stall_cnt, flush_cnt;
  logic        timeout_err;
  logic [1:0]  state;

  logic        pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b;
  logic        ifid_clr_b, idex_clr_b, exmem_clr_b, memwb_clr_b;
  logic [3:0]  valid_b;
  logic [3:0]  stall_cnt_b, flush_cnt_b;
  logic        timeout_err_b;
  logic [1:0]  state_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MAX_WAIT(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .mem_branch_taken(mem_branch_taken),
    .mem_busy(mem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_clr(ifid_clr), .idex_clr(idex_clr), .exmem_clr(exmem_clr), .memwb_clr(memwb_clr),
    .valid(valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .timeout_err(timeout_err), .state(state)
  );

  pipe_ctrl #(.MAX_WAIT(16), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .mem_branch_taken(mem_branch_taken),
    .mem_busy(mem_busy),
    .pc_en(pc_en_b), .ifid_en(ifid_en_b), .idex_en(idex_en_b), .exmem_en(exmem_en_b),
    .memwb_en(memwb_en_b),
    .ifid_clr(ifid_clr_b), .idex_clr(idex_clr_b), .exmem_clr(exmem_clr_b), .memwb_clr(memwb_clr_b),
    .valid(valid_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b),
    .timeout_err(timeout_err_b), .state(state_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [4:0] ens();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  endfunction

  function automatic logic [3:0] clrs();
    return {ifid_clr, idex_clr, exmem_clr, memwb_clr};
  endfunction

  task automatic set_lu(input logic on, input logic [4:0] rd);
    ex_memread = on;
    ex_rd      = rd;
    id_rs2     = rd;
    id_use_rs2 = on;
    id_rs1     = 5'd1;
    id_use_rs1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    mem_busy = 1'b0;
    mem_branch_taken = 1'b0;
    set_lu(1'b0, 5'd0);

    // Cold start
    #1;
    chk("rst_en", 32'(ens()), 32'b00000);
    chk("rst_clr", 32'(clrs()), 32'b1111);
    tick(2);
    chk("rst_valid", 32'(valid), 32'b0000);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_en", 32'(ens()), 32'b11111);
    chk("idle_clr", 32'(clrs()), 32'b0000);
    tick(); chk("fill1", 32'(valid), 32'b0001);
    tick(); chk("fill2", 32'(valid), 32'b0011);
    tick(); chk("fill3", 32'(valid), 32'b0111);
    tick(); chk("fill4", 32'(valid), 32'b1111);

    // Load-use on rs2 = 5
    set_lu(1'b1, 5'd5);
    #1;
    chk("lu_en", 32'(ens()), 32'b00111);
    chk("lu_clr", 32'(clrs()), 32'b0100);
    tick();
    chk("lu_stall", 32'(stall_cnt), 32'd1);
    chk("lu_valid", 32'(valid), 32'b1101);
    chk("lu_bubble_en", 32'(ens()), 32'b11111);
    set_lu(1'b0, 5'd0);
    tick(); chk("lu_v2", 32'(valid), 32'b1011);
    tick(); chk("lu_v3", 32'(valid), 32'b0111);
    tick(); chk("lu_v4", 32'(valid), 32'b1111);

    // Load to XZR never stalls
    set_lu(1'b1, 5'd31);
    #1;
    chk("xzr_en", 32'(ens()), 32'b11111);
    chk("xzr_clr", 32'(clrs()), 32'b0000);
    tick();
    chk("xzr_stall", 32'(stall_cnt), 32'd1);
    chk("xzr_valid", 32'(valid), 32'b1111);

    // Flush overrides a simultaneous load-use
    set_lu(1'b1, 5'd5);
    mem_branch_taken = 1'b1;
    #1;
    chk("fl_en", 32'(ens()), 32'b11111);
    chk("fl_clr", 32'(clrs()), 32'b1110);
    tick();
    chk("fl_flush", 32'(flush_cnt), 32'd1);
    chk("fl_stall", 32'(stall_cnt), 32'd1);
    chk("fl_valid", 32'(valid), 32'b1000);
    set_lu(1'b0, 5'd0);
    mem_branch_taken = 1'b0;

    // Memory wait for three cycles, valid frozen at 1000
    mem_busy = 1'b1;
    #1;
    chk("mw_en", 32'(ens()), 32'b00000);
    chk("mw_clr", 32'(clrs()), 32'b0000);
    tick();
    chk("mw_state1", 32'(state), 32'd1);
    chk("mw_valid1", 32'(valid), 32'b1000);
    tick(2);
    chk("mw_state3", 32'(state), 32'd1);
    chk("mw_valid3", 32'(valid), 32'b1000);
    chk("mw_stall", 32'(stall_cnt), 32'd4);
    chk("mw_en3", 32'(ens()), 32'b00000);
    mem_busy = 1'b0;
    #1;
    chk("mw_rel_en", 32'(ens()), 32'b11111);
    tick();
    chk("mw_run", 32'(state), 32'd0);
    chk("mw_valid_go", 32'(valid), 32'b0001);
    chk("mw_stall_end", 32'(stall_cnt), 32'd4);

    // Timeout: 16 busy cycles tolerated, the 17th halts
    mem_busy = 1'b1;
    tick(16);
    chk("to_wait16", 32'(state), 32'd1);
    chk("to_tmo16", 32'(timeout_err), 32'd0);
    tick(4);
    chk("to_halt", 32'(state), 32'd2);
    chk("to_tmo", 32'(timeout_err), 32'd1);
    chk("to_valid", 32'(valid), 32'b0001);
    mem_busy = 1'b0;
    #1;
    chk("halt_en", 32'(ens()), 32'b00000);
    chk("halt_clr", 32'(clrs()), 32'b0000);
    tick(2);
    chk("halt_stay", 32'(state), 32'd2);
    chk("halt_tmo", 32'(timeout_err), 32'd1);
    chk("halt_valid", 32'(valid), 32'b0001);
    reset = 1'b1;
    #1;
    chk("halt_rst_clr", 32'(clrs()), 32'b1111);
    tick();
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_tmo", 32'(timeout_err), 32'd0);
    chk("post_rst_valid", 32'(valid), 32'b0000);
    reset = 1'b0;

    // Saturation: 20 load-use cycles (every other cycle) into a 4-bit counter
    tick(4);
    chk("sat_fill", 32'(valid_b), 32'b1111);
    set_lu(1'b1, 5'd7);
    tick(40);
    chk("sat_stall4", 32'(stall_cnt_b), 32'd15);
    chk("sat_stall16", 32'(stall_cnt), 32'd20);
    set_lu(1'b0, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
